// File: rtl/row_window_feeder_pkg.sv
// Shared types and default widths for the row window feeder.
// Widths mirror the CAE-wide DATA_WIDTH / INPUT_SIZE defines.
package row_window_feeder_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_INPUT_SIZE = 15;
  localparam int ROW_RING_DEPTH = 4;

  typedef enum logic {
    IDLE,
    RUN
  } feeder_state_t;

  typedef logic [DEF_INPUT_SIZE-1:0][DEF_DATA_WIDTH-1:0] row_t;

endpackage

// File: rtl/row_window_feeder_ring.sv
// Four-row ring: one element write port and three whole-row read ports
// at rd_ptr, rd_ptr+1 and rd_ptr+2 (mod 4).
module row_ring_bank
  import row_window_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int INPUT_SIZE = DEF_INPUT_SIZE,
  localparam int COL_W = $clog2(INPUT_SIZE)
) (
  input  logic                                 clk_i,
  input  logic                                 rst,
  input  logic                                 wr_en,
  input  logic [1:0]                           wr_ptr,
  input  logic [COL_W-1:0]                     col_cnt,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  input  logic [1:0]                           rd_ptr,
  output logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0] row1,
  output logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0] row2,
  output logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0] row3
);

  logic [ROW_RING_DEPTH-1:0][INPUT_SIZE-1:0][DATA_WIDTH-1:0] ring;

  genvar gi;
  generate
    for (gi = 0; gi < ROW_RING_DEPTH; gi++) begin : g_row
      logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0] row_reg;

      always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
          row_reg <= '0;
        end else if (wr_en && (wr_ptr == 2'(gi))) begin
          row_reg[col_cnt] <= wr_data;
        end
      end

      assign ring[gi] = row_reg;
    end
  endgenerate

  // 2-bit pointer arithmetic wraps naturally around the 4-deep ring.
  assign row1 = ring[rd_ptr];
  assign row2 = ring[rd_ptr + 2'd1];
  assign row3 = ring[rd_ptr + 2'd2];

endmodule

// File: rtl/row_window_feeder.sv
// Raster-to-3-row-window feeder: buffers rows in a 4-deep ring and holds a
// stable window for the conv engine until it reports completion.
module row_window_feeder
  import row_window_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int INPUT_SIZE = DEF_INPUT_SIZE,
  parameter int NUM_ROWS   = 15,
  localparam int WIN_W = $clog2(NUM_ROWS),
  localparam int COL_W = $clog2(INPUT_SIZE)
) (
  input  logic                                 clk_i,
  input  logic                                 rst,
  input  logic                                 pix_valid,
  input  logic [DATA_WIDTH-1:0]                pix_data,
  output logic                                 pix_ready,
  output logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0] data_row1_o,
  output logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0] data_row2_o,
  output logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0] data_row3_o,
  output logic                                 conv_enable,
  input  logic                                 conv_done,
  output logic [WIN_W-1:0]                     win_idx,
  output logic                                 frame_done
);

  feeder_state_t    state_reg;
  logic [2:0]       occ_reg;
  logic [2:0]       occ_next;
  logic [1:0]       wr_ptr_reg;
  logic [1:0]       rd_ptr_reg;
  logic [COL_W-1:0] col_cnt_reg;
  logic             accept;
  logic             row_done;
  logic             retire;
  logic             last_win;
  logic [2:0]       retire_cnt;

  assign pix_ready  = (occ_reg != 3'd4);
  assign accept     = pix_valid & pix_ready;
  assign row_done   = accept && (col_cnt_reg == COL_W'(INPUT_SIZE - 1));
  assign retire     = (state_reg == RUN) && conv_done;
  assign last_win   = (win_idx == WIN_W'(NUM_ROWS - 3));
  // The last window of a frame frees all three of its rows at once.
  assign retire_cnt = !retire ? 3'd0 : (last_win ? 3'd3 : 3'd1);
  assign occ_next   = occ_reg + {2'b00, row_done} - retire_cnt;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      occ_reg     <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      col_cnt_reg <= '0;
      conv_enable <= 1'b0;
      win_idx     <= '0;
      frame_done  <= 1'b0;
    end else begin
      if (accept) begin
        col_cnt_reg <= row_done ? '0 : col_cnt_reg + 1'b1;
        if (row_done) begin
          wr_ptr_reg <= wr_ptr_reg + 2'd1;
        end
      end
      occ_reg    <= occ_next;
      rd_ptr_reg <= rd_ptr_reg + retire_cnt[1:0];
      frame_done <= retire && last_win;

      case (state_reg)
        IDLE: begin
          if (occ_reg >= 3'd3) begin
            state_reg   <= RUN;
            conv_enable <= 1'b1;
          end
        end
        RUN: begin
          if (conv_done) begin
            state_reg   <= IDLE;
            conv_enable <= 1'b0;
            win_idx     <= last_win ? '0 : win_idx + 1'b1;
          end
        end
        default: begin
          state_reg   <= IDLE;
          conv_enable <= 1'b0;
        end
      endcase
    end
  end

  row_ring_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .INPUT_SIZE(INPUT_SIZE)
  ) u_ring (
    .clk_i  (clk_i),
    .rst    (rst),
    .wr_en  (accept),
    .wr_ptr (wr_ptr_reg),
    .col_cnt(col_cnt_reg),
    .wr_data(pix_data),
    .rd_ptr (rd_ptr_reg),
    .row1   (data_row1_o),
    .row2   (data_row2_o),
    .row3   (data_row3_o)
  );

endmodule

// File: tb/tb_row_window_feeder.sv
// Directed bench for row_window_feeder: window assembly, backpressure,
// full-frame sequencing, frame overlap and mid-run reset.
module tb_row_window_feeder;

  localparam int DW = 16;
  localparam int IS = 15;
  localparam int NR = 15;

  logic                   clk_i = 1'b0;
  logic                   rst;
  logic                   pix_valid;
  logic [DW-1:0]          pix_data;
  logic                   pix_ready;
  logic [IS-1:0][DW-1:0]  data_row1_o;
  logic [IS-1:0][DW-1:0]  data_row2_o;
  logic [IS-1:0][DW-1:0]  data_row3_o;
  logic                   conv_enable;
  logic                   conv_done;
  logic [3:0]             win_idx;
  logic                   frame_done;

  int tests_run    = 0;
  int tests_failed = 0;
  int fd_cnt       = 0;
  int windows      = 0;

  row_window_feeder #(
    .DATA_WIDTH(DW),
    .INPUT_SIZE(IS),
    .NUM_ROWS  (NR)
  ) dut (
    .clk_i      (clk_i),
    .rst        (rst),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .data_row1_o(data_row1_o),
    .data_row2_o(data_row2_o),
    .data_row3_o(data_row3_o),
    .conv_enable(conv_enable),
    .conv_done  (conv_done),
    .win_idx    (win_idx),
    .frame_done (frame_done)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (frame_done) fd_cnt++;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, act);
    end
  endtask

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic push(input logic [DW-1:0] v);
    int n = 0;
    pix_valid = 1'b1;
    pix_data  = v;
    while (!pix_ready && n < 200) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= 200) check("push_timeout", 0, 1);
    @(posedge clk_i); #1;
    pix_valid = 1'b0;
  endtask

  task automatic push_row(input int base, input int r);
    for (int c = 0; c < IS; c++) push(DW'(base + r * 16 + c));
  endtask

  task automatic wait_enable(input string tag);
    int n = 0;
    while (!conv_enable && n < 100) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= 100) check(tag, 0, 1);
  endtask

  task automatic pulse_done();
    wait_enable("enable_timeout");
    conv_done = 1'b1;
    @(posedge clk_i); #1;
    conv_done = 1'b0;
  endtask

  task automatic run_engine(input int max_cycles, input int fd_base);
    int cnt = 0;
    for (int i = 0; i < max_cycles && fd_cnt == fd_base; i++) begin
      @(posedge clk_i); #1;
      if (conv_done) begin
        conv_done = 1'b0;
        cnt = 0;
      end else if (conv_enable) begin
        cnt++;
        if (cnt == 5) begin
          conv_done = 1'b1;
          windows++;
        end
      end
    end
    if (fd_cnt == fd_base) check("engine_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    rst = 1'b1;
    @(posedge clk_i); #1;
    rst = 1'b0;
  endtask

  initial begin
    int fd_base;
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_data  = '0;
    conv_done = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_pix_ready", pix_ready, 1);
    check("rst_conv_enable", conv_enable, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_win_idx", win_idx, 0);
    check("rst_row1", data_row1_o, 0);
    rst = 1'b0;

    // First window after three rows
    for (int r = 0; r < 3; r++) push_row(0, r);
    check("t1_enable_after_N", conv_enable, 0);
    check("t1_occ", dut.occ_reg, 3);
    @(posedge clk_i); #1;
    check("t1_enable_after_N1", conv_enable, 1);
    check("t1_row1_c0", data_row1_o[0], 16'h0000);
    check("t1_row2_c7", data_row2_o[7], 16'h0017);
    check("t1_row3_c14", data_row3_o[14], 16'h002E);
    check("t1_win_idx", win_idx, 0);

    // Fourth row fills the ring; one done slides the window
    push_row(0, 3);
    check("t2_ready_full", pix_ready, 0);
    pulse_done();
    check("t2_enable_low", conv_enable, 0);
    check("t2_win_idx", win_idx, 1);
    check("t2_ready_back", pix_ready, 1);
    @(posedge clk_i); #1;
    check("t2_enable_high", conv_enable, 1);
    check("t2_row1_c0", data_row1_o[0], 16'h0010);
    check("t2_row3_c14", data_row3_o[14], 16'h003E);

    // Backpressure: element held while the ring is full
    push_row(0, 4);
    pix_valid = 1'b1;
    pix_data  = 16'h0050;
    for (int i = 0; i < 3; i++) begin
      check("t3_ready_stall", pix_ready, 0);
      check("t3_col_held", dut.col_cnt_reg, 0);
      @(posedge clk_i); #1;
    end
    conv_done = 1'b1;
    @(posedge clk_i); #1;
    conv_done = 1'b0;
    check("t3_ready_after_retire", pix_ready, 1);
    check("t3_win_idx", win_idx, 2);
    @(posedge clk_i); #1;
    pix_valid = 1'b0;
    check("t3_col_accepted", dut.col_cnt_reg, 1);
    check("t3_enable", conv_enable, 1);
    check("t3_row1_c0", data_row1_o[0], 16'h0020);
    check("t3_row3_c0", data_row3_o[0], 16'h0040);

    // Full frame with an engine replying 5 cycles after each enable
    do_reset();
    fd_base = fd_cnt;
    windows = 0;
    fork
      for (int r = 0; r < NR; r++) push_row(0, r);
      run_engine(1000, fd_base);
    join
    repeat (5) @(posedge clk_i);
    #1;
    check("t4_windows", windows, 13);
    check("t4_frame_done_cycles", fd_cnt - fd_base, 1);
    check("t4_occ", dut.occ_reg, 0);
    check("t4_win_idx", win_idx, 0);
    check("t4_enable", conv_enable, 0);

    // Back-to-back frames; row completion coincides with the last done
    do_reset();
    for (int r = 0; r < 4; r++) push_row(0, r);
    for (int w = 0; w < 12; w++) begin
      pulse_done();
      check($sformatf("t5_win_idx_%0d", w + 1), win_idx, w + 1);
      if (w < 11) push_row(0, w + 4);
    end
    for (int c = 0; c < IS - 1; c++) push(DW'(16'h0100 + c));
    wait_enable("t5_enable_timeout");
    check("t5_last_row1_c0", data_row1_o[0], 16'h00C0);
    pix_valid = 1'b1;
    pix_data  = 16'h010E;
    conv_done = 1'b1;
    @(posedge clk_i); #1;
    pix_valid = 1'b0;
    conv_done = 1'b0;
    check("t5_occ", dut.occ_reg, 1);
    check("t5_frame_done", frame_done, 1);
    check("t5_win_idx", win_idx, 0);
    check("t5_enable", conv_enable, 0);
    push_row(16'h0100, 1);
    push_row(16'h0100, 2);
    @(posedge clk_i); #1;
    check("t5_f2_enable", conv_enable, 1);
    check("t5_f2_row1_c0", data_row1_o[0], 16'h0100);
    check("t5_f2_row3_c14", data_row3_o[14], 16'h012E);

    // Reset during RUN with a partial row pending
    for (int c = 0; c < 5; c++) push(DW'(16'h0300 + c));
    rst = 1'b1;
    #1;
    check("t6_enable", conv_enable, 0);
    check("t6_ready", pix_ready, 1);
    check("t6_frame_done", frame_done, 0);
    check("t6_win_idx", win_idx, 0);
    check("t6_row1", data_row1_o, 0);
    check("t6_row3", data_row3_o, 0);
    @(posedge clk_i); #1;
    rst = 1'b0;
    for (int r = 0; r < 3; r++) push_row(16'h0200, r);
    @(posedge clk_i); #1;
    check("t6_new_enable", conv_enable, 1);
    check("t6_row1_c0", data_row1_o[0], 16'h0200);
    check("t6_row2_c5", data_row2_o[5], 16'h0215);
    check("t6_row3_c14", data_row3_o[14], 16'h022E);
    check("t6_win_idx", win_idx, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
